// File: rtl/ls_unit.sv
// Load/store unit: one memory instruction at a time, word-aligned RAM requests with
// read-modify-write for sub-word stores, unshifted IO accesses, one completion per issue.
module ls_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_SIZE   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sb_valid,
  output logic                  sb_vacant,
  input  logic                  sb_store,
  input  logic [2:0]            sb_funct,
  input  logic [ADDR_WIDTH-1:0] sb_rs1_val,
  input  logic [DATA_WIDTH-1:0] sb_rs2_val,
  input  logic [ADDR_WIDTH-1:0] sb_imm,
  input  logic [REG_SIZE-1:0]   sb_rd,
  output logic                  mc_valid,
  output logic                  mc_we,
  output logic [ADDR_WIDTH-1:0] mc_addr,
  output logic [DATA_WIDTH-1:0] mc_src,
  input  logic                  mc_done,
  input  logic [DATA_WIDTH-1:0] mc_data,
  output logic                  wb_valid,
  output logic [REG_SIZE-1:0]   wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_err
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t                r_state;
  logic                  r_store;
  logic [2:0]            r_funct;
  logic [1:0]            r_off;
  logic                  r_io;
  logic [DATA_WIDTH-1:0] r_rs2;
  logic [REG_SIZE-1:0]   r_rd;
  logic                  r_vacant;
  logic                  r_mc_valid;
  logic                  r_mc_we;
  logic [ADDR_WIDTH-1:0] r_mc_addr;
  logic [DATA_WIDTH-1:0] r_mc_src;
  logic                  r_wb_valid;
  logic [REG_SIZE-1:0]   r_wb_rd;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic                  r_wb_err;

  logic [ADDR_WIDTH-1:0] w_ea;
  logic                  w_io;
  logic                  w_legal;
  logic                  w_mis;
  logic                  w_err;
  logic                  w_direct_wr;
  logic [ADDR_WIDTH-1:0] w_addr;

  function automatic logic [31:0] f_load_ext(input logic [31:0] w, input logic [2:0] f,
                                             input logic [1:0] off);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (f)
      3'b000:  f_load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  f_load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  f_load_ext = {24'h000000, sh[7:0]};
      3'b101:  f_load_ext = {16'h0000, sh[15:0]};
      default: f_load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] f_store_merge(input logic [31:0] w, input logic [31:0] d,
                                                input logic [2:0] f, input logic [1:0] off);
    logic [31:0] mask;
    logic [31:0] data;
    case (f)
      3'b000: begin
        mask = 32'h0000_00FF << {off, 3'b000};
        data = {24'h000000, d[7:0]} << {off, 3'b000};
      end
      3'b001: begin
        mask = 32'h0000_FFFF << {off, 3'b000};
        data = {16'h0000, d[15:0]} << {off, 3'b000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = d;
      end
    endcase
    f_store_merge = (w & ~mask) | (data & mask);
  endfunction

  assign w_ea    = sb_rs1_val + sb_imm;
  assign w_io    = (w_ea[17:16] == 2'b11);
  // Stores allow SB/SH/SW; loads additionally allow LBU/LHU.
  assign w_legal = sb_store ? (!sb_funct[2] && (sb_funct[1:0] != 2'b11))
                            : ((sb_funct[1:0] != 2'b11) && !(sb_funct[2] && sb_funct[1]));
  assign w_mis   = ((sb_funct[1:0] == 2'b01) && w_ea[0]) ||
                   ((sb_funct[1:0] == 2'b10) && (w_ea[1:0] != 2'b00));
  assign w_err       = !w_legal || w_mis;
  assign w_direct_wr = sb_store && ((sb_funct[1:0] == 2'b10) || w_io);
  assign w_addr      = w_io ? w_ea : {w_ea[ADDR_WIDTH-1:2], 2'b00};

  // Control FSM with all outputs registered; error path spends one quiet RESP cycle first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_store    <= 1'b0;
      r_funct    <= 3'b000;
      r_off      <= 2'b00;
      r_io       <= 1'b0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_vacant   <= 1'b1;
      r_mc_valid <= 1'b0;
      r_mc_we    <= 1'b0;
      r_mc_addr  <= '0;
      r_mc_src   <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sb_valid && r_vacant) begin
            r_store  <= sb_store;
            r_funct  <= sb_funct;
            r_off    <= w_ea[1:0];
            r_io     <= w_io;
            r_rs2    <= sb_rs2_val;
            r_rd     <= sb_rd;
            r_vacant <= 1'b0;
            if (w_err) begin
              r_state <= S_RESP;
            end else begin
              r_mc_valid <= 1'b1;
              r_mc_addr  <= w_addr;
              if (w_direct_wr) begin
                r_mc_we  <= 1'b1;
                r_mc_src <= sb_rs2_val;
                r_state  <= S_WR;
              end else begin
                r_mc_we <= 1'b0;
                r_state <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          if (mc_done) begin
            if (r_store) begin
              r_mc_we  <= 1'b1;
              r_mc_src <= f_store_merge(mc_data, r_rs2, r_funct, r_off);
              r_state  <= S_WR;
            end else begin
              r_mc_valid <= 1'b0;
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= f_load_ext(mc_data, r_funct, r_io ? 2'b00 : r_off);
              r_wb_err   <= 1'b0;
              r_state    <= S_RESP;
            end
          end
        end
        S_WR: begin
          if (mc_done) begin
            r_mc_valid <= 1'b0;
            r_mc_we    <= 1'b0;
            r_wb_valid <= 1'b1;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_wb_err   <= 1'b0;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (r_wb_valid) begin
            r_wb_valid <= 1'b0;
            r_vacant   <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_wb_err   <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_vacant   <= 1'b1;
          r_mc_valid <= 1'b0;
          r_mc_we    <= 1'b0;
          r_wb_valid <= 1'b0;
        end
      endcase
    end
  end

  assign sb_vacant = r_vacant;
  assign mc_valid  = r_mc_valid;
  assign mc_we     = r_mc_we;
  assign mc_addr   = r_mc_addr;
  assign mc_src    = r_mc_src;
  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign wb_err    = r_wb_err;

endmodule

// File: tb/tb_ls_unit.sv
// Directed bench for ls_unit: a one-cycle-latency memory responder and hand-computed
// expectations checked cycle by cycle at the falling edge.
module tb_ls_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        sb_valid;
  logic        sb_vacant;
  logic        sb_store;
  logic [2:0]  sb_funct;
  logic [31:0] sb_rs1_val;
  logic [31:0] sb_rs2_val;
  logic [31:0] sb_imm;
  logic [4:0]  sb_rd;
  logic        mc_valid;
  logic        mc_we;
  logic [31:0] mc_addr;
  logic [31:0] mc_src;
  logic        mc_done;
  logic [31:0] mc_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;

  int n_cmp = 0;
  int n_err = 0;
  int n_rd  = 0;
  int n_wr  = 0;
  int rd0;
  int wr0;
  logic seen_wb;

  ls_unit dut (
    .clk(clk), .rst(rst),
    .sb_valid(sb_valid), .sb_vacant(sb_vacant), .sb_store(sb_store), .sb_funct(sb_funct),
    .sb_rs1_val(sb_rs1_val), .sb_rs2_val(sb_rs2_val), .sb_imm(sb_imm), .sb_rd(sb_rd),
    .mc_valid(mc_valid), .mc_we(mc_we), .mc_addr(mc_addr), .mc_src(mc_src),
    .mc_done(mc_done), .mc_data(mc_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  // Memory model: done one cycle after a request is seen, and transaction counting.
  always @(posedge clk) begin
    if (rst) begin
      mc_done <= 1'b0;
    end else begin
      mc_done <= mc_valid && !mc_done;
      if (mc_valid && mc_done) begin
        if (mc_we) n_wr <= n_wr + 1;
        else       n_rd <= n_rd + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge of cycle T; returns at the falling edge of T+1.
  task automatic issue(input logic st, input logic [2:0] f, input logic [31:0] rs1,
                       input logic [31:0] imm, input logic [31:0] rs2, input logic [4:0] rd);
    sb_valid = 1'b1; sb_store = st; sb_funct = f;
    sb_rs1_val = rs1; sb_imm = imm; sb_rs2_val = rs2; sb_rd = rd;
    @(negedge clk);
    sb_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [2:0] f, input logic [31:0] ea,
                          input logic [4:0] rd, input logic [31:0] exp_addr,
                          input logic [31:0] exp_data);
    issue(1'b0, f, ea, 32'h0, 32'h0, rd);
    check({tag, "_valid"}, {31'b0, mc_valid}, 32'd1);
    check({tag, "_we"}, {31'b0, mc_we}, 32'd0);
    check({tag, "_addr"}, mc_addr, exp_addr);
    step(2);
    check({tag, "_wbv"}, {31'b0, wb_valid}, 32'd1);
    check({tag, "_data"}, wb_data, exp_data);
    check({tag, "_rd"}, {27'b0, wb_rd}, {27'b0, rd});
    step(1);
    check({tag, "_vacant"}, {31'b0, sb_vacant}, 32'd1);
  endtask

  task automatic run_err(input string tag, input logic st, input logic [2:0] f,
                         input logic [31:0] ea);
    rd0 = n_rd; wr0 = n_wr;
    issue(st, f, ea, 32'h0, 32'h5, 5'd9);
    check({tag, "_noreq"}, {31'b0, mc_valid}, 32'd0);
    check({tag, "_early"}, {31'b0, wb_valid}, 32'd0);
    step(1);
    check({tag, "_wbv"}, {31'b0, wb_valid}, 32'd1);
    check({tag, "_err"}, {31'b0, wb_err}, 32'd1);
    check({tag, "_rd"}, {27'b0, wb_rd}, 32'd0);
    check({tag, "_data"}, wb_data, 32'd0);
    step(1);
    check({tag, "_vacant"}, {31'b0, sb_vacant}, 32'd1);
    check({tag, "_nomem"}, n_rd + n_wr, rd0 + wr0);
  endtask

  initial begin
    rst = 1'b1; sb_valid = 1'b0; sb_store = 1'b0; sb_funct = 3'b000;
    sb_rs1_val = 32'h0; sb_rs2_val = 32'h0; sb_imm = 32'h0; sb_rd = 5'd0;
    mc_data = 32'h0;
    step(3);
    check("rst_mc_valid", {31'b0, mc_valid}, 32'd0);
    check("rst_mc_we", {31'b0, mc_we}, 32'd0);
    check("rst_mc_addr", mc_addr, 32'd0);
    check("rst_mc_src", mc_src, 32'd0);
    check("rst_wb", {wb_valid, wb_err, wb_rd}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_vacant", {31'b0, sb_vacant}, 32'd1);
    rst = 1'b0;
    step(1);

    // LW with the address split between rs1 and imm.
    mc_data = 32'h80FF7F01;
    issue(1'b0, 3'b010, 32'h80, 32'h80, 32'h0, 5'd5);
    check("lw_valid", {31'b0, mc_valid}, 32'd1);
    check("lw_addr", mc_addr, 32'h100);
    check("lw_vacant_busy", {31'b0, sb_vacant}, 32'd0);
    step(1);
    check("lw_wb_early", {31'b0, wb_valid}, 32'd0);
    step(1);
    check("lw_wbv", {31'b0, wb_valid}, 32'd1);
    check("lw_data", wb_data, 32'h80FF7F01);
    check("lw_rd", {27'b0, wb_rd}, 32'd5);
    check("lw_mc_drop", {31'b0, mc_valid}, 32'd0);
    check("lw_vacant_resp", {31'b0, sb_vacant}, 32'd0);
    step(1);
    check("lw_pulse", {31'b0, wb_valid}, 32'd0);
    check("lw_hold", wb_data, 32'h80FF7F01);
    check("lw_vacant", {31'b0, sb_vacant}, 32'd1);

    run_load("lb", 3'b000, 32'h103, 5'd1, 32'h100, 32'hFFFFFF80);
    run_load("lbu", 3'b100, 32'h103, 5'd2, 32'h100, 32'h00000080);
    run_load("lh", 3'b001, 32'h102, 5'd3, 32'h100, 32'hFFFF80FF);
    run_load("lhu", 3'b101, 32'h100, 5'd4, 32'h100, 32'h00007F01);
    run_load("lb1", 3'b000, 32'h101, 5'd6, 32'h100, 32'h0000007F);

    // Sub-word store to RAM: read, merge, write.
    mc_data = 32'h11223344;
    issue(1'b1, 3'b000, 32'h100, 32'h1, 32'h000000AB, 5'd7);
    check("sb_rd_we", {31'b0, mc_we}, 32'd0);
    check("sb_rd_addr", mc_addr, 32'h100);
    step(2);
    check("sb_wr_valid", {31'b0, mc_valid}, 32'd1);
    check("sb_wr_we", {31'b0, mc_we}, 32'd1);
    check("sb_wr_addr", mc_addr, 32'h100);
    check("sb_wr_src", mc_src, 32'h1122AB44);
    step(1);
    check("sb_wr_stable", mc_src, 32'h1122AB44);
    check("sb_wb_early", {31'b0, wb_valid}, 32'd0);
    step(1);
    check("sb_wbv", {31'b0, wb_valid}, 32'd1);
    check("sb_wb_rd", {27'b0, wb_rd}, 32'd0);
    check("sb_wb_data", wb_data, 32'd0);
    step(1);

    // SH to upper half of a RAM word.
    mc_data = 32'hA5A5A5A5;
    issue(1'b1, 3'b001, 32'h200, 32'h2, 32'h0000BEEF, 5'd7);
    step(2);
    check("sh_src", mc_src, 32'hBEEFA5A5);
    step(3);

    // SW goes straight to a write.
    rd0 = n_rd;
    issue(1'b1, 3'b010, 32'h1F0, 32'h10, 32'hDEADBEEF, 5'd8);
    check("sw_we", {31'b0, mc_we}, 32'd1);
    check("sw_addr", mc_addr, 32'h200);
    check("sw_src", mc_src, 32'hDEADBEEF);
    step(2);
    check("sw_wbv", {31'b0, wb_valid}, 32'd1);
    check("sw_noread", n_rd, rd0);
    step(1);

    run_err("lw_mis", 1'b0, 3'b010, 32'h102);
    run_err("sh_mis", 1'b1, 3'b001, 32'h103);
    run_err("ld_f011", 1'b0, 3'b011, 32'h100);
    run_err("st_f100", 1'b1, 3'b100, 32'h100);

    // IO byte store: single unshifted write, no read.
    rd0 = n_rd; wr0 = n_wr;
    mc_data = 32'hFFFFFFFF;
    issue(1'b1, 3'b000, 32'h30000, 32'h0, 32'h00000041, 5'd3);
    check("io_sb_we", {31'b0, mc_we}, 32'd1);
    check("io_sb_addr", mc_addr, 32'h30000);
    check("io_sb_src", mc_src, 32'h00000041);
    step(2);
    check("io_sb_wbv", {31'b0, wb_valid}, 32'd1);
    check("io_sb_noread", n_rd, rd0);
    check("io_sb_onewr", n_wr, wr0 + 1);
    step(1);

    mc_data = 32'h1234565A;
    run_load("io_lbu", 3'b100, 32'h30000, 5'd10, 32'h30000, 32'h0000005A);
    mc_data = 32'h000000C3;
    run_load("io_lb", 3'b000, 32'h30001, 5'd11, 32'h30001, 32'hFFFFFFC3);

    // Reset asserted in the write phase of an RMW store.
    mc_data = 32'h11223344;
    issue(1'b1, 3'b000, 32'h100, 32'h1, 32'h000000AB, 5'd7);
    step(2);
    check("rw_in_wr", {31'b0, mc_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("rw_valid_drop", {31'b0, mc_valid}, 32'd0);
    check("rw_vacant", {31'b0, sb_vacant}, 32'd1);
    step(1);
    rst = 1'b0;
    seen_wb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (wb_valid) seen_wb = 1'b1;
    end
    check("rw_no_wb", {31'b0, seen_wb}, 32'd0);
    mc_data = 32'h80FF7F01;
    run_load("rw_lw", 3'b010, 32'h100, 5'd12, 32'h100, 32'h80FF7F01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
